// File: rtl/ext_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_bridge
// Description : Bridges one wide core word request (ADDR_W address, DATA_W
//               data) onto a narrow multiplexed external memory bus. Each
//               request becomes address slices strobed with ALE, followed by
//               BUS_W-wide data beats qualified by active-low WE_n / OE_n.
//               The external memory is BUS_W wide and addressed by
//               EXT_W = ADDR_W + log2(DATA_W/BUS_W) bits; beat b of a word
//               targets external address {addr, b}.
// Ports       : clk, rst (async, active low)
//               core side : req_valid, req_ready, req_we, req_addr, req_wdata,
//                           rsp_valid, rsp_rdata, rsp_err
//               pin side  : bus_out, bus_ale, bus_aph, bus_we_n, bus_oe_n,
//                           bus_din, bus_rdy
// Options     : `define EXT_BUS_READY_EN to let bus_rdy stretch data beats,
//               with a TIMEOUT abort that reports through rsp_err. Without
//               it bus_rdy is ignored and rsp_err is tied low.
// Revision    : 1.0  initial release
// ============================================================================
module ext_bus_bridge #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int BUS_W       = 4,
    parameter int PIN_W       = 7,
    parameter int WAIT_CYCLES = 1,
    parameter int TIMEOUT     = 15,
    localparam int c_N_BEAT     = DATA_W / BUS_W,
    localparam int c_BEAT_IDX_W = $clog2(c_N_BEAT),
    localparam int c_EXT_W      = ADDR_W + c_BEAT_IDX_W,
    localparam int c_N_APH      = (c_EXT_W + PIN_W - 1) / PIN_W,
    localparam int c_APH_W      = (c_N_APH > 1) ? $clog2(c_N_APH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic [PIN_W-1:0]   bus_out,
    output logic               bus_ale,
    output logic [c_APH_W-1:0] bus_aph,
    output logic               bus_we_n,
    output logic               bus_oe_n,
    input  logic [BUS_W-1:0]   bus_din,
    input  logic               bus_rdy
);

    localparam int c_BEAT_W = (c_BEAT_IDX_W > 0) ? c_BEAT_IDX_W : 1;
    localparam int c_PAD_W  = c_N_APH * PIN_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_APH_W-1:0]  r_aph, w_aph_nxt;
    logic [c_BEAT_W-1:0] r_beat, w_beat_nxt;
    logic [3:0]          r_hold, w_hold_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic                r_we, w_we_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0]   r_acc, w_acc_nxt;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                w_beat_end;

    logic [c_EXT_W-1:0]  w_ext;
    logic [c_PAD_W-1:0]  w_ext_pad;
    logic [PIN_W-1:0]    w_out_nxt;
    logic                w_ale_nxt, w_we_n_nxt, w_oe_n_nxt, w_valid_nxt, w_ready_nxt;

`ifdef EXT_BUS_READY_EN
    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [c_TMO_W-1:0]  r_tmo, w_tmo_nxt;
    logic                w_err_nxt;
`else
    logic w_unused_rdy;
    assign w_unused_rdy = bus_rdy;
`endif

    // ------------------------------------------------------------------
    // State register; all pin outputs are registered from next-state values
    // so strobes never glitch and reset drops them asynchronously.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_aph     <= '0;
            r_beat    <= '0;
            r_hold    <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_acc     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            bus_out   <= '0;
            bus_ale   <= 1'b0;
            bus_aph   <= '0;
            bus_we_n  <= 1'b1;
            bus_oe_n  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_aph     <= w_aph_nxt;
            r_beat    <= w_beat_nxt;
            r_hold    <= w_hold_nxt;
            r_addr    <= w_addr_nxt;
            r_we      <= w_we_nxt;
            r_wdata   <= w_wdata_nxt;
            r_acc     <= w_acc_nxt;
            req_ready <= w_ready_nxt;
            rsp_valid <= w_valid_nxt;
            rsp_rdata <= w_rdata_nxt;
            bus_out   <= w_out_nxt;
            bus_ale   <= w_ale_nxt;
            bus_aph   <= w_aph_nxt;
            bus_we_n  <= w_we_n_nxt;
            bus_oe_n  <= w_oe_n_nxt;
        end
    end

`ifdef EXT_BUS_READY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo   <= '0;
            rsp_err <= 1'b0;
        end else begin
            r_tmo   <= w_tmo_nxt;
            rsp_err <= w_err_nxt;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_aph_nxt   = r_aph;
        w_beat_nxt  = r_beat;
        w_hold_nxt  = r_hold;
        w_addr_nxt  = r_addr;
        w_we_nxt    = r_we;
        w_wdata_nxt = r_wdata;
        w_acc_nxt   = r_acc;
        w_rdata_nxt = rsp_rdata;
        w_beat_end  = 1'b0;
`ifdef EXT_BUS_READY_EN
        w_tmo_nxt   = r_tmo;
        w_err_nxt   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_addr_nxt  = req_addr;
                    w_we_nxt    = req_we;
                    w_wdata_nxt = req_wdata;
                    w_acc_nxt   = '0;
                    w_beat_nxt  = '0;
                    w_aph_nxt   = c_APH_W'(c_N_APH - 1);
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (r_aph == '0) begin
                    w_state_nxt = r_we ? S_WR : S_RD;
                    w_hold_nxt  = 4'(WAIT_CYCLES);
                end else begin
                    w_aph_nxt = r_aph - 1'b1;
                end
            end
            S_WR, S_RD: begin
                if (r_hold != '0) begin
                    w_hold_nxt = r_hold - 1'b1;
                end else begin
`ifdef EXT_BUS_READY_EN
                    // Ready is only consulted once the fixed hold has elapsed;
                    // every low cycle from then on stretches the beat.
                    if (!bus_rdy) begin
                        if (r_tmo == c_TMO_W'(TIMEOUT - 1)) begin
                            w_tmo_nxt   = '0;
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_tmo_nxt = r_tmo + 1'b1;
                        end
                    end else begin
                        w_tmo_nxt  = '0;
                        w_beat_end = 1'b1;
                    end
`else
                    w_beat_end = 1'b1;
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_beat_end) begin
            if (r_state == S_RD) begin
                w_acc_nxt[int'(r_beat)*BUS_W +: BUS_W] = bus_din;
            end
            if (r_beat == c_BEAT_W'(c_N_BEAT - 1)) begin
                w_state_nxt = S_DONE;
            end else begin
                // Upper address slices are still latched externally; only
                // the slice holding the beat index needs refreshing.
                w_beat_nxt  = r_beat + 1'b1;
                w_aph_nxt   = '0;
                w_state_nxt = S_ADDR;
            end
        end

        // Reads publish the accumulated word on entry to DONE (including a
        // timeout abort); writes leave the previous read data in place.
        if (w_state_nxt == S_DONE && !r_we) begin
            w_rdata_nxt = w_acc_nxt;
        end
    end

    // External address of the upcoming cycle: {word address, beat index}.
    generate
        if (c_BEAT_IDX_W > 0) begin : g_ext_beat
            assign w_ext = {w_addr_nxt, w_beat_nxt[c_BEAT_IDX_W-1:0]};
        end else begin : g_ext_word
            assign w_ext = w_addr_nxt;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pin values for the upcoming cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_ext_pad                = '0;
        w_ext_pad[c_EXT_W-1:0]   = w_ext;
        w_out_nxt                = '0;
        w_ale_nxt                = 1'b0;
        w_we_n_nxt               = 1'b1;
        w_oe_n_nxt               = 1'b1;
        w_valid_nxt              = 1'b0;
        w_ready_nxt              = 1'b0;
        case (w_state_nxt)
            S_IDLE: w_ready_nxt = 1'b1;
            S_ADDR: begin
                w_ale_nxt = 1'b1;
                w_out_nxt = w_ext_pad[int'(w_aph_nxt)*PIN_W +: PIN_W];
            end
            S_WR: begin
                w_we_n_nxt             = 1'b0;
                w_out_nxt[BUS_W-1:0]   = w_wdata_nxt[int'(w_beat_nxt)*BUS_W +: BUS_W];
            end
            S_RD:    w_oe_n_nxt  = 1'b0;
            S_DONE:  w_valid_nxt = 1'b1;
            default: w_ready_nxt = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_bus_bridge
// Description : Self-checking bench for ext_bus_bridge with default
//               parameters. Contains a nibble-wide external memory device
//               (address latched on ALE, written while WE_n is low, read data
//               presented combinationally) and a word-level reference memory.
//               Every transaction's pin activity is compared cycle by cycle
//               against a trace derived from the bus protocol rules.
//               Honours `EXT_BUS_READY_EN for the ready/timeout cases.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ext_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [12:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [6:0]  bus_out;
    logic        bus_ale, bus_we_n, bus_oe_n, bus_rdy;
    logic [0:0]  bus_aph;
    logic [3:0]  bus_din;

    always #5 clk = ~clk;

    ext_bus_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_out   (bus_out),
        .bus_ale   (bus_ale),
        .bus_aph   (bus_aph),
        .bus_we_n  (bus_we_n),
        .bus_oe_n  (bus_oe_n),
        .bus_din   (bus_din),
        .bus_rdy   (bus_rdy)
    );

    // External nibble memory device
    logic [3:0]  dev_mem [16384] = '{default: 4'h0};
    logic [6:0]  lat0 = '0, lat1 = '0;
    logic [13:0] dev_ea;
    assign dev_ea  = {lat1, lat0};
    assign bus_din = dev_mem[dev_ea];

    always @(posedge clk) begin
        if (bus_ale) begin
            if (bus_aph == 1'b0) lat0 <= bus_out;
            else                 lat1 <= bus_out;
        end
        if (!bus_we_n) dev_mem[dev_ea] <= bus_out[3:0];
    end

    // Word-level reference model
    logic [7:0] ref_mem [8192] = '{default: 8'h00};
    logic [7:0] last_rd = 8'h00;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic ale, input logic wen, input logic oen,
                                       input logic rv, input logic [3:0] aph, input logic [7:0] o);
        return {ale, wen, oen, rv, aph, o};
    endfunction

    // Pin snapshot; aph and data only meaningful while a strobe is active.
    function automatic logic [15:0] obs();
        logic act;
        act = bus_ale | ~bus_we_n | ~bus_oe_n;
        return {bus_ale, bus_we_n, bus_oe_n, rsp_valid,
                bus_ale ? 4'(bus_aph) : 4'd0, act ? 8'(bus_out) : 8'd0};
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (req_ready !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
        end
    endtask

    // One full transaction with cycle-accurate pin trace and response check.
    task automatic txn(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input string nm);
        logic [15:0] exp_q [$];
        logic [13:0] e;
        logic [15:0] got;
        logic [15:0] bad_a, bad_e;
        int          bad_k;
        for (int b = 0; b < 2; b++) begin
            e = {addr, 1'(b)};
            if (b == 0) begin
                exp_q.push_back(mk(1, 1, 1, 0, 4'd1, 8'(e >> 7)));
            end
            exp_q.push_back(mk(1, 1, 1, 0, 4'd0, 8'(e[6:0])));
            for (int w = 0; w < 2; w++) begin
                if (we) exp_q.push_back(mk(0, 0, 1, 0, 4'd0, 8'((b == 0) ? wd[3:0] : wd[7:4])));
                else    exp_q.push_back(mk(0, 1, 0, 0, 4'd0, 8'd0));
            end
        end
        exp_q.push_back(mk(0, 1, 1, 1, 4'd0, 8'd0));

        wait_ready();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        bad_k = -1;
        bad_a = '0;
        bad_e = '0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 1'b0;
                req_we    = 1'($urandom);
                req_addr  = 13'($urandom);
                req_wdata = 8'($urandom);
            end
            got = obs();
            if (got !== exp_q[k] && bad_k < 0) begin
                bad_k = k + 1;
                bad_a = got;
                bad_e = exp_q[k];
            end
        end
        n_vec++;
        if (bad_k >= 0) begin
            n_miss++;
            $display("FAIL trace %s cycle %0d: got 0x%04h expected 0x%04h", nm, bad_k, bad_a, bad_e);
        end
        chk({nm, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        chk({nm, "_err"}, 32'(rsp_err), 32'd0);
        if (we) ref_mem[addr] = wd;
        else    last_rd = exp_rd;
    endtask

    initial begin
        logic        seen;
        logic [13:0] idx;
        logic        rw;
        logic [12:0] ra;
        logic [7:0]  rd;
        int          found;

        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        bus_rdy   = 1'b1;

        vecs[0]  = '{1'b1, 13'h123,  8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 13'h123,  8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 13'h0000, 8'h3C, 8'hA5};
        vecs[3]  = '{1'b1, 13'h1FFF, 8'hC3, 8'hA5};
        vecs[4]  = '{1'b0, 13'h0000, 8'h00, 8'h3C};
        vecs[5]  = '{1'b0, 13'h1FFF, 8'h00, 8'hC3};
        vecs[6]  = '{1'b1, 13'h1FFE, 8'h00, 8'hC3};
        vecs[7]  = '{1'b0, 13'h1FFE, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, 13'h1FFF, 8'h00, 8'hC3};
        vecs[9]  = '{1'b1, 13'h1FFE, 8'h69, 8'hC3};
        vecs[10] = '{1'b0, 13'h1FFE, 8'h00, 8'h69};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err",   32'(rsp_err),   32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_out",   32'(bus_out),   32'd0);
        chk("rst_ale",   32'(bus_ale),   32'd0);
        chk("rst_aph",   32'(bus_aph),   32'd0);
        chk("rst_we_n",  32'(bus_we_n),  32'd1);
        chk("rst_oe_n",  32'(bus_oe_n),  32'd1);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, $sformatf("vec%0d", i));
        end
        idx = {13'h123, 1'b1};
        chk("dev_hi_nibble_123", 32'(dev_mem[idx]), 32'hA);

`ifdef EXT_BUS_READY_EN
        // Ready held low for three cycles on beat 0 of a read
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 13'h123;
        found     = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (rsp_valid && found == 0) begin
                found = k;
                chk("rdy_wait_err",   32'(rsp_err),   32'd0);
                chk("rdy_wait_rdata", 32'(rsp_rdata), 32'hA5);
            end
            bus_rdy = !(k >= 4 && k <= 6);
        end
        chk("rdy_wait_latency", 32'(found), 32'd11);
        last_rd = 8'hA5;

        // Ready stuck low: timeout abort
        wait_ready();
        bus_rdy   = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 13'h123;
        found     = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (rsp_valid && found == 0) begin
                found = k;
                chk("tmo_err",   32'(rsp_err),   32'd1);
                chk("tmo_rdata", 32'(rsp_rdata), 32'h00);
            end
        end
        bus_rdy = 1'b1;
        chk("tmo_latency", 32'(found), 32'd19);
        chk("tmo_idle", 32'(req_ready), 32'd1);
        last_rd = 8'h00;
`endif

        // Back-to-back: req_valid held high; fields changed while busy
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 13'h300;
        req_wdata = 8'h5A;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_we    = 1'b0;
                req_wdata = 8'hFF;
            end
            if (k == 8) begin
                chk("b2b_done_valid", 32'(rsp_valid), 32'd1);
                chk("b2b_done_ready", 32'(req_ready), 32'd0);
            end
            if (k == 9) chk("b2b_idle_ready", 32'(req_ready), 32'd1);
            if (k == 10) begin
                chk("b2b_second_ale",   32'(bus_ale),   32'd1);
                chk("b2b_second_ready", 32'(req_ready), 32'd0);
                req_valid = 1'b0;
            end
        end
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (rsp_valid) found = 1;
        end
        chk("b2b_rsp_seen", 32'(found), 32'd1);
        chk("b2b_rdata", 32'(rsp_rdata), 32'h5A);
        ref_mem[13'h300] = 8'h5A;
        last_rd = 8'h5A;

        // Reset during beat-0 write
        txn(1'b1, 13'h1000, 8'h33, last_rd, "pre_rst");
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 13'h1000;
        req_wdata = 8'hCC;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_active", 32'(bus_we_n), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_we_n", 32'(bus_we_n), 32'd1);
        chk("abort_ale",  32'(bus_ale),  32'd0);
        chk("abort_oe_n", 32'(bus_oe_n), 32'd1);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_rdata", 32'(rsp_rdata), 32'd0);
        idx = {13'h1000, 1'b1};
        chk("abort_beat1_mem", 32'(dev_mem[idx]), 32'h3);
        last_rd = 8'h00;

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom);
            ra = 13'h200 + 13'($urandom_range(0, 31));
            rd = 8'($urandom);
            txn(rw, ra, rd, rw ? last_rd : ref_mem[ra], $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
